// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C single-byte write master.
// Contents:
//   i2c_state_t   - transaction phase of the master FSM
//   I2C_WRITE_BIT - R/W bit appended to the address (0 = write)
//   I2C_ADDR_W    - width of the 7-bit target address
//   I2C_DATA_W    - width of the data byte
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } i2c_state_t;

    localparam logic I2C_WRITE_BIT = 1'b0;
    localparam int   I2C_ADDR_W    = 7;
    localparam int   I2C_DATA_W    = 8;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe generator for the I2C master.
// Emits a one-cycle tick every CLK_DIV clocks while enabled; the count is
// held at zero whenever disabled so every transaction starts on a fresh
// quarter boundary.
// Ports:
//   clk_in    - system clock
//   reset_in  - synchronous, active-high reset
//   enable_in - count while high, clear while low
//   tick_out  - one-cycle strobe at the end of each quarter period
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic enable_in,
    output logic tick_out
);

    localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

    logic [15:0] count;

    always_ff @(posedge clk_in) begin
        if (reset_in || !enable_in) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign tick_out = enable_in && (count == LAST_COUNT);

endmodule

// File: rtl/i2c_write_master.sv
// I2C bus master performing one single-byte write per accepted start pulse:
// START, 7-bit address + W, ACK, data byte, ACK, STOP.
// Ports:
//   clk_in         - system clock
//   reset_in       - synchronous, active-high reset
//   start_pulse_in - one-cycle transaction request (ignored while busy)
//   dev_addr_in    - target address, captured on accept
//   data_in        - byte to write, captured on accept
//   sda_in         - resolved SDA pad level
//   scl_low_out    - 1 pulls SCL low, 0 releases it
//   sda_low_out    - 1 pulls SDA low, 0 releases it
//   busy_out       - transaction in progress
//   done_pulse_out - one-cycle pulse in the final cycle of a transaction
//   ack_error_out  - the last transaction saw a NACK
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_pulse_in,
    input  logic [I2C_ADDR_W-1:0] dev_addr_in,
    input  logic [I2C_DATA_W-1:0] data_in,
    input  logic                  sda_in,
    output logic                  scl_low_out,
    output logic                  sda_low_out,
    output logic                  busy_out,
    output logic                  done_pulse_out,
    output logic                  ack_error_out
);

    i2c_state_t            state, state_next;
    logic [1:0]            quarter, quarter_next;
    logic [3:0]            bit_count, bit_count_next;
    logic [7:0]            shift_reg, shift_next;
    logic [I2C_DATA_W-1:0] data_reg, data_next;
    logic                  nack, nack_next;
    logic                  ack_error, ack_error_next;
    logic                  tick;
    logic                  last_quarter;
    logic                  sample_point;

    assign busy_out      = (state != IDLE);
    assign ack_error_out = ack_error;

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .enable_in(busy_out),
        .tick_out (tick)
    );

    // A reset mid-transaction simply abandons the bus; no STOP is issued.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= IDLE;
            quarter   <= '0;
            bit_count <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            nack      <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            state     <= state_next;
            quarter   <= quarter_next;
            bit_count <= bit_count_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            nack      <= nack_next;
            ack_error <= ack_error_next;
        end
    end

    // Phases advance on the tick that ends quarter 3; the slave's ACK is
    // sampled on the tick that ends quarter 2, the middle of the SCL-high half.
    assign last_quarter = tick && (quarter == 2'd3);
    assign sample_point = tick && (quarter == 2'd2);

    always_comb begin
        state_next     = state;
        quarter_next   = tick ? quarter + 2'd1 : quarter;
        bit_count_next = bit_count;
        shift_next     = shift_reg;
        data_next      = data_reg;
        nack_next      = nack;
        ack_error_next = ack_error;
        scl_low_out    = 1'b0;
        sda_low_out    = 1'b0;
        done_pulse_out = 1'b0;

        case (state)
            IDLE: begin
                if (start_pulse_in) begin
                    state_next     = START;
                    quarter_next   = 2'd0;
                    bit_count_next = 4'd0;
                    shift_next     = {dev_addr_in, I2C_WRITE_BIT};
                    data_next      = data_in;
                    nack_next      = 1'b0;
                    ack_error_next = 1'b0;
                end
            end

            START: begin
                sda_low_out = quarter[1];
                if (last_quarter) begin
                    state_next = ADDR;
                end
            end

            ADDR: begin
                scl_low_out = !quarter[1];
                sda_low_out = !shift_reg[7];
                if (last_quarter) begin
                    shift_next = shift_reg << 1;
                    if (bit_count == 4'd7) begin
                        bit_count_next = 4'd0;
                        state_next     = ADDR_ACK;
                    end else begin
                        bit_count_next = bit_count + 4'd1;
                    end
                end
            end

            ADDR_ACK: begin
                scl_low_out = !quarter[1];
                if (sample_point) begin
                    nack_next = sda_in;
                    if (sda_in) begin
                        ack_error_next = 1'b1;
                    end
                end
                if (last_quarter) begin
                    state_next = nack ? STOP : DATA;
                end
            end

            DATA: begin
                scl_low_out = !quarter[1];
                sda_low_out = !data_reg[I2C_DATA_W-1];
                if (last_quarter) begin
                    data_next = data_reg << 1;
                    if (bit_count == 4'd7) begin
                        bit_count_next = 4'd0;
                        state_next     = DATA_ACK;
                    end else begin
                        bit_count_next = bit_count + 4'd1;
                    end
                end
            end

            DATA_ACK: begin
                scl_low_out = !quarter[1];
                if (sample_point && sda_in) begin
                    ack_error_next = 1'b1;
                end
                if (last_quarter) begin
                    state_next = STOP;
                end
            end

            STOP: begin
                scl_low_out = (quarter == 2'd0);
                sda_low_out = !quarter[1];
                if (last_quarter) begin
                    state_next     = IDLE;
                    done_pulse_out = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Self-checking bench for i2c_write_master with CLK_DIV = 4.
// An open-drain bus with pull-ups is formed from the master's pull-down
// enables and a scheduled slave that ACKs on request. A transaction-level
// model builds the expected per-quarter line drive from the address, data
// and slave behaviour and is compared against the DUT every cycle; SDA
// values seen at each SCL rising edge are also compared to literal bit
// strings, and SDA edges while SCL is high must be START or STOP.
module tb_i2c_write_master;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_pulse = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] data = '0;
    logic       scl_low, sda_low, busy, done, ack_error;
    logic       slave_low;
    logic       sda_bus, scl_bus;
    logic       slave_ack_addr = 1'b1;
    logic       slave_ack_data = 1'b1;
    logic       check_en = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    assign sda_bus = ~(sda_low | slave_low);
    assign scl_bus = ~scl_low;

    i2c_write_master #(
        .CLK_DIV(D)
    ) dut (
        .clk_in        (clk),
        .reset_in      (reset),
        .start_pulse_in(start_pulse),
        .dev_addr_in   (dev_addr),
        .data_in       (data),
        .sda_in        (sda_bus),
        .scl_low_out   (scl_low),
        .sda_low_out   (sda_low),
        .busy_out      (busy),
        .done_pulse_out(done),
        .ack_error_out (ack_error)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected master drive per quarter, from the protocol rules alone:
    // START, each bit as four quarters (SCL low, low, high, high), then STOP.
    function automatic void build_wave(input logic [6:0] a, input logic [7:0] d,
                                       input logic ack_a,
                                       output logic [79:0] scl_w,
                                       output logic [79:0] sda_w,
                                       output int len);
        logic bits[$];
        int k;
        k = 0;
        scl_w = '0;
        sda_w = '0;
        for (int i = 6; i >= 0; i--) bits.push_back(a[i]);
        bits.push_back(1'b0);
        bits.push_back(1'b1);
        if (ack_a) begin
            for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
            bits.push_back(1'b1);
        end
        for (int q = 0; q < 4; q++) begin
            scl_w[k] = 1'b0;
            sda_w[k] = (q >= 2);
            k++;
        end
        foreach (bits[i]) begin
            for (int q = 0; q < 4; q++) begin
                scl_w[k] = (q < 2);
                sda_w[k] = !bits[i];
                k++;
            end
        end
        for (int q = 0; q < 4; q++) begin
            scl_w[k] = (q == 0);
            sda_w[k] = (q < 2);
            k++;
        end
        len = k;
    endfunction

    // Transaction model: m_t counts clocks since busy began.
    logic        m_busy = 1'b0;
    int          m_t = 0;
    int          m_len = 0;
    logic [79:0] m_scl = '0;
    logic [79:0] m_sda = '0;
    logic        m_ack_err = 1'b0;
    logic [79:0] w_scl, w_sda;
    int          w_len;

    always @(posedge clk) begin
        if (reset) begin
            m_busy    <= 1'b0;
            m_t       <= 0;
            m_ack_err <= 1'b0;
        end else if (m_busy) begin
            if (m_t == m_len * D - 1) m_busy <= 1'b0;
            else m_t <= m_t + 1;
            if (m_t == 39 * D - 1 && !slave_ack_addr) m_ack_err <= 1'b1;
            if (m_t == 75 * D - 1 && slave_ack_addr && !slave_ack_data) m_ack_err <= 1'b1;
        end else if (start_pulse) begin
            build_wave(dev_addr, data, slave_ack_addr, w_scl, w_sda, w_len);
            m_scl     <= w_scl;
            m_sda     <= w_sda;
            m_len     <= w_len;
            m_busy    <= 1'b1;
            m_t       <= 0;
            m_ack_err <= 1'b0;
        end
    end

    // Slave pulls SDA low for the whole ACK bit when configured to answer.
    always_comb begin
        slave_low = 1'b0;
        if (m_busy && slave_ack_addr) begin
            if (m_t / D >= 36 && m_t / D <= 39) slave_low = 1'b1;
            if (slave_ack_data && m_t / D >= 72 && m_t / D <= 75) slave_low = 1'b1;
        end
    end

    // Per-cycle compare, bus bit collector and START/STOP protocol check.
    logic        prev_valid = 1'b0;
    logic        prev_scl, prev_sda;
    logic [63:0] bit_hist = '0;
    int          bit_n = 0;
    int          busy_cycles = 0;
    int          done_count = 0;

    always @(negedge clk) begin
        logic [4:0] exp_vec;
        logic       allowed;
        if (check_en) begin
            if (m_busy)
                exp_vec = {m_scl[m_t / D], m_sda[m_t / D], 1'b1, (m_t == m_len * D - 1), m_ack_err};
            else
                exp_vec = {4'b0000, m_ack_err};
            check_output("outputs{scl,sda,busy,done,ackerr}",
                         int'({scl_low, sda_low, busy, done, ack_error}), int'(exp_vec));
            if (prev_valid) begin
                if (!prev_scl && scl_bus) begin
                    bit_hist = {bit_hist[62:0], sda_bus};
                    bit_n++;
                end
                if (prev_scl && scl_bus && (sda_bus != prev_sda)) begin
                    allowed = m_busy && ((!sda_bus && m_t == 2 * D) ||
                                         (sda_bus && m_t == (m_len - 2) * D));
                    check_output("sda_edge_while_scl_high_is_start_or_stop", int'(allowed), 1);
                end
            end
            prev_scl    = scl_bus;
            prev_sda    = sda_bus;
            prev_valid  = 1'b1;
            busy_cycles += int'(busy);
            done_count  += int'(done);
        end
    end

    task automatic apply_stimulus(input logic [6:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        dev_addr    = a;
        data        = d;
        start_pulse = 1'b1;
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
    endtask

    task automatic pulse_after(input int n);
        repeat (n) @(posedge clk);
        #1;
        start_pulse = 1'b1;
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_output("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_transaction(input string name, input logic [6:0] a, input logic [7:0] d,
                                   input logic ack_a, input logic ack_d,
                                   input int exp_busy, input int exp_nbits,
                                   input logic [31:0] exp_bits, input logic exp_ack);
        int          bc0, dc0, bn0;
        logic [63:0] mask;
        bc0 = busy_cycles;
        dc0 = done_count;
        bn0 = bit_n;
        slave_ack_addr = ack_a;
        slave_ack_data = ack_d;
        apply_stimulus(a, d);
        wait_done(1000);
        mask = (64'd1 << exp_nbits) - 64'd1;
        check_output({name, "_busy_cycles"}, busy_cycles - bc0, exp_busy);
        check_output({name, "_done_pulses"}, done_count - dc0, 1);
        check_output({name, "_scl_rises"}, bit_n - bn0, exp_nbits);
        check_output({name, "_sda_bits"}, int'(bit_hist & mask), int'(exp_bits));
        check_output({name, "_ack_error"}, int'(ack_error), int'(exp_ack));
    endtask

    initial begin
        int bc0, dc0;

        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        check_output("reset_outputs", int'({scl_low, sda_low, busy, done, ack_error}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full write, slave ACKs address and data.
        run_transaction("full_write", 7'h48, 8'hA5, 1'b1, 1'b1, 320, 19,
                        32'(19'b1001000_0_0_10100101_0_0), 1'b0);

        // Address NACK: nobody answers, no data bits follow.
        run_transaction("addr_nack", 7'h3C, 8'h11, 1'b0, 1'b0, 176, 10,
                        32'(10'b0111100_0_1_0), 1'b1);

        // Data NACK: full length, error flagged.
        run_transaction("data_nack", 7'h50, 8'hFF, 1'b1, 1'b0, 320, 19,
                        32'(19'b1010000_0_0_11111111_1_0), 1'b1);

        // A following good transaction clears the error flag on accept.
        slave_ack_addr = 1'b1;
        slave_ack_data = 1'b1;
        apply_stimulus(7'h12, 8'h34);
        @(negedge clk);
        check_output("accept_clears_ack_error", int'({busy, ack_error}), 2);
        wait_done(1000);
        check_output("good_after_nack_ack_error", int'(ack_error), 0);

        // Pulses 10 and 100 cycles after accept and in the done cycle are dropped.
        bc0 = busy_cycles;
        dc0 = done_count;
        apply_stimulus(7'h21, 8'h5A);
        pulse_after(9);
        pulse_after(89);
        pulse_after(219);
        repeat (400) @(posedge clk);
        #1;
        check_output("ignored_pulses_busy_cycles", busy_cycles - bc0, 320);
        check_output("ignored_pulses_done_pulses", done_count - dc0, 1);

        // Reset during ADDR bit 1, quarter 1, then a clean restart.
        apply_stimulus(7'h48, 8'hA5);
        repeat (37) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_output("pre_reset_scl_low", int'({scl_low, busy}), 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("mid_reset_outputs", int'({scl_low, sda_low, busy, done, ack_error}), 0);
        bc0 = busy_cycles;
        apply_stimulus(7'h48, 8'hA5);
        @(negedge clk);
        check_output("restart_start_q0", int'({scl_low, sda_low, busy}), 1);
        wait_done(1000);
        check_output("restart_busy_cycles", busy_cycles - bc0, 320);
        check_output("restart_ack_error", int'(ack_error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
